// File: rtl/spi_pin_arbiter.sv
// Round-robin arbiter sharing one SPI pad bank between NREQ fabric masters and an
// external MCU; pad drive is registered and the bank always ends a tenure tristated.
module spi_pin_arbiter #(
  parameter int NREQ     = 4,
  parameter int CS_HOLD  = 1,
  parameter int TURN_CYC = 2,
  parameter int MAX_HOLD = 4096,
  parameter int SYNC_STG = 2
) (
  input  logic            pll_clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  input  logic [NREQ-1:0] m_sck,
  input  logic [NREQ-1:0] m_mosi,
  input  logic [NREQ-1:0] m_cs_n,
  output logic            m_miso,
  input  logic            ext_busy,
  output logic            pad_sck_o,
  output logic            pad_mosi_o,
  output logic            pad_cs_n_o,
  output logic            pad_oe,
  input  logic            pad_miso_i,
  output logic            timeout_err
);

  localparam int IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HCW   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int PMAX  = (CS_HOLD > TURN_CYC) ? CS_HOLD : TURN_CYC;
  localparam int PHW   = $clog2(PMAX + 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [PHW-1:0] CS_LAST   = PHW'(CS_HOLD - 1);
  localparam logic [PHW-1:0] TURN_LAST = PHW'(TURN_CYC - 1);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE, TURN} state_t;

  state_t                state_reg;
  logic [IDXW-1:0]       owner_reg;
  logic [IDXW-1:0]       rr_ptr_reg;
  logic [NREQ-1:0]       lockout_reg;
  logic [HCW-1:0]        hold_cnt_reg;
  logic [PHW-1:0]        phase_cnt_reg;
  logic [SYNC_STG-1:0]   busy_sync_reg;

  logic                  ext_busy_s;
  logic [NREQ-1:0]       avail;
  logic [NREQ-1:0]       lockout_next;
  logic                  pick_valid;
  logic [IDXW-1:0]       pick_idx;

  function automatic logic [IDXW-1:0] wrap_idx(input int base, input int k);
    int j;
    j = base + k;
    if (j >= NREQ) j = j - NREQ;
    return IDXW'(j);
  endfunction

  assign ext_busy_s   = busy_sync_reg[SYNC_STG-1];
  assign m_miso       = pad_miso_i;
  assign avail        = req & ~lockout_reg;
  // A lockout bit survives only while its requester keeps req high.
  assign lockout_next = lockout_reg & req;

  // Scan downward so the last hit is the first requester at or above rr_ptr.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (avail[wrap_idx(int'(rr_ptr_reg), k)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_idx(int'(rr_ptr_reg), k);
      end
    end
  end

  always_ff @(posedge pll_clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      owner_reg     <= '0;
      rr_ptr_reg    <= '0;
      lockout_reg   <= '0;
      hold_cnt_reg  <= '0;
      phase_cnt_reg <= '0;
      busy_sync_reg <= '0;
      gnt           <= '0;
      pad_oe        <= 1'b0;
      pad_cs_n_o    <= 1'b1;
      pad_sck_o     <= 1'b0;
      pad_mosi_o    <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      busy_sync_reg <= {busy_sync_reg[SYNC_STG-2:0], ext_busy};
      timeout_err   <= 1'b0;
      lockout_reg   <= lockout_next;
      case (state_reg)
        IDLE: begin
          pad_cs_n_o <= 1'b1;
          pad_sck_o  <= 1'b0;
          pad_mosi_o <= 1'b0;
          if (!ext_busy_s && pick_valid) begin
            state_reg    <= GRANT;
            gnt          <= NREQ'(1) << pick_idx;
            owner_reg    <= pick_idx;
            rr_ptr_reg   <= wrap_idx(int'(pick_idx), 1);
            hold_cnt_reg <= '0;
            pad_oe       <= 1'b1;
          end else begin
            gnt    <= '0;
            pad_oe <= 1'b0;
          end
        end
        GRANT: begin
          hold_cnt_reg <= hold_cnt_reg + 1'b1;
          // A req drop wins over a coincident timeout: plain release, no penalty.
          if (!req[owner_reg] || (MAX_HOLD != 0 && hold_cnt_reg == HOLD_LAST)) begin
            state_reg     <= RELEASE;
            gnt           <= '0;
            phase_cnt_reg <= '0;
            pad_cs_n_o    <= 1'b1;
            pad_sck_o     <= 1'b0;
            pad_mosi_o    <= 1'b0;
            if (req[owner_reg]) begin
              timeout_err <= 1'b1;
              lockout_reg <= lockout_next | (NREQ'(1) << owner_reg);
            end
          end else begin
            pad_sck_o  <= m_sck[owner_reg];
            pad_mosi_o <= m_mosi[owner_reg];
            pad_cs_n_o <= m_cs_n[owner_reg];
          end
        end
        RELEASE: begin
          if (phase_cnt_reg == CS_LAST) begin
            state_reg     <= TURN;
            phase_cnt_reg <= '0;
            pad_oe        <= 1'b0;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end
        default: begin
          pad_oe <= 1'b0;
          if (phase_cnt_reg == TURN_LAST) begin
            state_reg     <= IDLE;
            phase_cnt_reg <= '0;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_pin_arbiter.sv
// Directed bench for spi_pin_arbiter: single master, round robin, timeout,
// external busy, reset mid-grant and pad pass-through.
module tb_spi_pin_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] m_sck;
  logic [3:0] m_mosi;
  logic [3:0] m_cs_n;
  logic       m_miso;
  logic       ext_busy;
  logic       pad_sck_o;
  logic       pad_mosi_o;
  logic       pad_cs_n_o;
  logic       pad_oe;
  logic       pad_miso_i;
  logic       timeout_err;

  int errors = 0;
  int checks = 0;

  spi_pin_arbiter #(
    .NREQ(4), .CS_HOLD(1), .TURN_CYC(2), .MAX_HOLD(16), .SYNC_STG(2)
  ) dut (
    .pll_clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .m_sck(m_sck), .m_mosi(m_mosi), .m_cs_n(m_cs_n), .m_miso(m_miso),
    .ext_busy(ext_busy), .pad_sck_o(pad_sck_o), .pad_mosi_o(pad_mosi_o),
    .pad_cs_n_o(pad_cs_n_o), .pad_oe(pad_oe), .pad_miso_i(pad_miso_i),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; ext_busy = 1'b0;
    m_sck = '0; m_mosi = '0; m_cs_n = '1; pad_miso_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [5:0] sck_vec  = 6'b101101;
  logic [5:0] mosi_vec = 6'b011001;
  logic [3:0] rr_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    // Reset state
    do_reset();
    chk("reset_gnt", gnt, 4'b0000);
    chk("reset_oe", pad_oe, 1'b0);
    chk("reset_cs_n", pad_cs_n_o, 1'b1);
    chk("reset_sck", pad_sck_o, 1'b0);
    chk("reset_mosi", pad_mosi_o, 1'b0);
    chk("reset_tmo", timeout_err, 1'b0);
    $display("txn reset: gnt=%b oe=%b cs_n=%b", gnt, pad_oe, pad_cs_n_o);

    // Single master: req at cycle 0, dropped at cycle 10
    req = 4'b0001;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("single_gnt", gnt, 4'b0001);
      chk("single_oe", pad_oe, 1'b1);
    end
    req = 4'b0000;
    tick();
    chk("single_rel_gnt", gnt, 4'b0000);
    chk("single_rel_cs", pad_cs_n_o, 1'b1);
    chk("single_rel_oe", pad_oe, 1'b1);
    tick();
    chk("single_turn_oe12", pad_oe, 1'b0);
    req = 4'b0001;
    tick();
    chk("single_turn_oe13", pad_oe, 1'b0);
    chk("single_turn_gnt13", gnt, 4'b0000);
    tick();
    chk("single_idle_gnt14", gnt, 4'b0000);
    tick();
    chk("single_regrant15", gnt, 4'b0001);
    $display("txn single: regrant gnt=%b", gnt);

    // Reset mid-grant with owner CS_N low; rr_ptr must return to 0
    do_reset();
    req = 4'b0010;
    m_cs_n = 4'b1101;
    tick();
    chk("rst_mid_gnt", gnt, 4'b0010);
    tick();
    chk("rst_mid_cs_low", pad_cs_n_o, 1'b0);
    rst = 1'b1;
    req = 4'b0110;
    tick();
    rst = 1'b0;
    chk("rst_mid_gnt0", gnt, 4'b0000);
    chk("rst_mid_oe0", pad_oe, 1'b0);
    chk("rst_mid_cs1", pad_cs_n_o, 1'b1);
    tick();
    chk("rst_mid_rrptr0", gnt, 4'b0010);
    $display("txn reset_mid_grant: post gnt=%b", gnt);

    // Round robin: all request, each owner drops after 4 cycles and re-asserts
    do_reset();
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      for (int h = 0; h < 4; h++) begin
        chk("rr_gnt", gnt, rr_order[n]);
        if (h < 3) tick();
      end
      req = req & ~rr_order[n];
      tick();
      chk("rr_released", gnt, 4'b0000);
      chk("rr_rel_cs", pad_cs_n_o, 1'b1);
      req = 4'b1111;
      for (int g = 0; g < 3; g++) begin
        tick();
        chk("rr_gap", gnt, 4'b0000);
      end
      $display("txn round_robin: grant %0d was %b", n, rr_order[n]);
    end

    // Timeout: MAX_HOLD=16, req[1] held forever
    do_reset();
    req = 4'b0010;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk("tmo_gnt", gnt, 4'b0010);
      chk("tmo_err_low", timeout_err, 1'b0);
    end
    tick();
    chk("tmo_forced_gnt", gnt, 4'b0000);
    chk("tmo_err_pulse", timeout_err, 1'b1);
    for (int c = 18; c <= 25; c++) begin
      tick();
      chk("tmo_lockout_gnt", gnt, 4'b0000);
      chk("tmo_err_once", timeout_err, 1'b0);
    end
    req = 4'b0000;
    tick();
    chk("tmo_drop_gnt", gnt, 4'b0000);
    req = 4'b0010;
    tick();
    chk("tmo_regrant", gnt, 4'b0010);
    $display("txn timeout: regrant gnt=%b", gnt);

    // External busy blocks grants; grant appears SYNC_STG+1 cycles after it falls
    do_reset();
    ext_busy = 1'b1;
    tick();
    tick();
    tick();
    req = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("busy_gnt", gnt, 4'b0000);
      chk("busy_oe", pad_oe, 1'b0);
    end
    ext_busy = 1'b0;
    tick();
    chk("busy_fall1", gnt, 4'b0000);
    tick();
    chk("busy_fall2", gnt, 4'b0000);
    tick();
    chk("busy_fall3_gnt", gnt, 4'b0100);
    $display("txn ext_busy: gnt=%b", gnt);

    // Pass-through under gnt[2]: pads lag owner by one cycle, m_miso is combinational
    do_reset();
    req = 4'b0100;
    m_cs_n = 4'b1011;
    tick();
    chk("pt_gnt", gnt, 4'b0100);
    for (int i = 0; i < 6; i++) begin
      m_sck  = sck_vec[i]  ? 4'b0100 : 4'b1011;
      m_mosi = mosi_vec[i] ? 4'b0100 : 4'b1011;
      pad_miso_i = i[0];
      #1;
      chk("pt_miso", m_miso, i[0]);
      tick();
      chk("pt_sck", pad_sck_o, sck_vec[i]);
      chk("pt_mosi", pad_mosi_o, mosi_vec[i]);
      chk("pt_cs_n", pad_cs_n_o, 1'b0);
      $display("txn pass_through %0d: sck=%b mosi=%b", i, pad_sck_o, pad_mosi_o);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
